channel_vote_window: RTL

CHANNEL_VOTE_WINDOW -- requirements
Module: channel_vote_window

---
 rtl/channel_vote_window.sv | 137 +++++++++++++
 1 files changed

// File: rtl/channel_vote_window.sv
// Windowed per-channel vote counter: counts 1-samples on each channel for WIN_LEN
// cycles, then flags channels whose count strictly exceeds the latched threshold.
module channel_vote_window #(
  parameter int NCH     = 9,
  parameter int WIN_LEN = 90,
  parameter int CNT_W   = 8
) (
  input  logic             fclk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             cont_mode,
  input  logic [CNT_W-1:0] thr,
  input  logic [NCH-1:0]   data,
  input  logic [4:0]       rd_sel,
  output logic [NCH-1:0]   hit,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rd_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EVAL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] cnt_d  [NCH];
  logic [CNT_W-1:0] snap_q [NCH];
  logic [NCH-1:0]   hit_q, hit_d;
  logic             busy_q, done_q;

  logic clr_cnt, acc_en, eval_en, load_thr;

  // State register
  always_ff @(posedge fclk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort always wins over start and evaluation
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !abort) state_d = ACCUM;
      ACCUM: begin
        if (abort)                       state_d = IDLE;
        else if (win_cnt_q == WIN_LAST)  state_d = EVAL;
      end
      EVAL: begin
        if (abort)          state_d = IDLE;
        else if (cont_mode) state_d = ACCUM;
        else                state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    clr_cnt  = 1'b0;
    acc_en   = 1'b0;
    eval_en  = 1'b0;
    load_thr = 1'b0;
    case (state_q)
      IDLE: begin
        clr_cnt  = start && !abort;
        load_thr = start && !abort;
      end
      ACCUM: begin
        clr_cnt = abort;
        acc_en  = !abort;
      end
      EVAL: begin
        // Counters are always cleared on leaving EVAL; the snapshot keeps the result.
        clr_cnt  = 1'b1;
        eval_en  = !abort;
        load_thr = !abort && cont_mode;
      end
      default: ;
    endcase
  end

  assign win_cnt_d = clr_cnt ? '0 : (acc_en ? win_cnt_q + 1'b1 : win_cnt_q);
  assign thr_d     = load_thr ? thr : thr_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign cnt_d[gi] = clr_cnt ? '0 :
                       (acc_en && data[gi] && (cnt_q[gi] != CNT_MAX)) ? cnt_q[gi] + 1'b1 :
                       cnt_q[gi];
    assign hit_d[gi] = cnt_q[gi] > thr_q;
  end

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      win_cnt_q <= '0;
      thr_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      win_cnt_q <= win_cnt_d;
      thr_q     <= thr_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= eval_en;
      if (eval_en) hit_q <= hit_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (eval_en) snap_q[i] <= cnt_q[i];
      end
    end
  end

  // Out-of-range selects fall through to zero
  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel == 5'(i)) rd_cnt = snap_q[i];
    end
  end

  assign hit  = hit_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
